// File: rtl/ram_8_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ram_8_sequencer
// Description : Store-and-forward burst initiator for an 8-word RAM port.
//               Optional checksum enabled by macro RAM_SEQ_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_8_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       len_m1,
    input  logic             abort,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ram_in,
    output logic [2:0]       ram_address,
    output logic             ram_load,
    input  logic [WIDTH-1:0] ram_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_next;
    logic [2:0] r_last;
    logic [2:0] w_last_next;
    logic       w_in_hs;
    logic       w_out_hs;
    logic       w_sum_clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            r_last  <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_last  <= w_last_next;
        end
    end

    // The RAM read is combinational, so the drain word is simply the RAM output.
    assign out_data = ram_out;
    assign busy     = (r_state != IDLE);

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_last_next  = r_last;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        ram_load     = 1'b0;
        ram_address  = 3'd0;
        ram_in       = '0;
        done         = 1'b0;
        w_in_hs      = 1'b0;
        w_out_hs     = 1'b0;
        w_sum_clear  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_last_next  = len_m1;
                    w_ptr_next   = 3'd0;
                    w_state_next = FILL;
                    w_sum_clear  = 1'b1;
                end
            end

            FILL: begin
                ram_address = r_ptr;
                ram_in      = in_data;
                in_ready    = !abort;
                w_in_hs     = in_valid && !abort;
                ram_load    = w_in_hs;
                if (abort) begin
                    w_ptr_next   = 3'd0;
                    w_state_next = IDLE;
                end else if (w_in_hs) begin
                    if (r_ptr == r_last) begin
                        w_ptr_next   = 3'd0;
                        w_state_next = DRAIN;
                    end else begin
                        w_ptr_next = r_ptr + 3'd1;
                    end
                end
            end

            DRAIN: begin
                ram_address = r_ptr;
                out_valid   = !abort;
                w_out_hs    = out_ready && !abort;
                if (abort) begin
                    w_ptr_next   = 3'd0;
                    w_state_next = IDLE;
                end else if (w_out_hs) begin
                    if (r_ptr == r_last) begin
                        done         = 1'b1;
                        w_ptr_next   = 3'd0;
                        w_state_next = IDLE;
                    end else begin
                        w_ptr_next = r_ptr + 3'd1;
                    end
                end
            end

            default: begin
                w_ptr_next   = 3'd0;
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef RAM_SEQ_CHECKSUM_EN
    logic [WIDTH-1:0] r_sum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else if (w_sum_clear) begin
            r_sum <= '0;
        end else if (w_out_hs) begin
            r_sum <= r_sum + ram_out;
        end
    end

    assign checksum = r_sum;
`else
    logic w_unused_sum;

    assign w_unused_sum = w_out_hs ^ w_sum_clear;
    assign checksum     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_8_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_8_sequencer
// Description : Directed bench for ram_8_sequencer with an 8-word RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_8_sequencer;

    localparam int C_WIDTH = 16;

    logic               clock;
    logic               reset_n;
    logic               start;
    logic [2:0]         len_m1;
    logic               abort;
    logic [C_WIDTH-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [C_WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [C_WIDTH-1:0] ram_in;
    logic [2:0]         ram_address;
    logic               ram_load;
    logic [C_WIDTH-1:0] ram_out;
    logic               busy;
    logic               done;
    logic [C_WIDTH-1:0] checksum;

    logic               preload;
    logic [C_WIDTH-1:0] mem [8];
    logic [C_WIDTH-1:0] bd  [8];

    int n_checks;
    int n_errors;

    ram_8_sequencer #(.WIDTH(C_WIDTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .len_m1      (len_m1),
        .abort       (abort),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ram_in      (ram_in),
        .ram_address (ram_address),
        .ram_load    (ram_load),
        .ram_out     (ram_out),
        .busy        (busy),
        .done        (done),
        .checksum    (checksum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (preload) begin
            for (int k = 0; k < 8; k++) mem[k] <= 16'hD000 + C_WIDTH'(k);
        end else if (ram_load) begin
            mem[ram_address] <= ram_in;
        end
    end
    assign ram_out = mem[ram_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Runs one burst of n words from bd[]; optional drain stall, mid-fill start, mid-drain reset.
    task automatic do_burst(input int n, input int stall_at, input int stall_n,
                            input int start_at, input int rst_at);
        logic [C_WIDTH-1:0] exp_sum;
        exp_sum   = '0;
        start     = 1'b1;
        len_m1    = 3'(n - 1);
        out_ready = 1'b1;
        @(negedge clock);
        check("idle_busy", busy, 0);
        cycle();
        for (int i = 0; i < n; i++) begin
            start    = (i == start_at);
            len_m1   = (i == start_at) ? 3'd0 : len_m1;
            in_valid = 1'b1;
            in_data  = bd[i];
            @(negedge clock);
            check("fill_ready", in_ready, 1);
            check("fill_load", ram_load, 1);
            check("fill_addr", ram_address, i);
            check("fill_data", ram_in, bd[i]);
            check("fill_busy", busy, 1);
            cycle();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                #2 reset_n = 1'b0;
                #1;
                check("rst_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_sum", checksum, 0);
                #2 reset_n = 1'b1;
                return;
            end
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clock);
                    check("stall_valid", out_valid, 1);
                    check("stall_addr", ram_address, i);
                    check("stall_data", out_data, bd[i]);
                    check("stall_done", done, 0);
                    cycle();
                end
                out_ready = 1'b1;
            end
            @(negedge clock);
            check("drain_valid", out_valid, 1);
            check("drain_addr", ram_address, i);
            check("drain_data", out_data, bd[i]);
            check("drain_done", done, (i == n - 1) ? 1 : 0);
            exp_sum = exp_sum + bd[i];
            cycle();
        end
        @(negedge clock);
        check("end_busy", busy, 0);
        check("end_valid", out_valid, 0);
`ifdef RAM_SEQ_CHECKSUM_EN
        check("end_sum", checksum, exp_sum);
`else
        check("end_sum", checksum, 0);
`endif
        cycle();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        preload   = 1'b1;
        reset_n   = 1'b1;
        start     = 1'b0;
        len_m1    = 3'd0;
        abort     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 reset_n = 1'b0;
        #7;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_load", ram_load, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", checksum, 0);
        check("rst_addr", ram_address, 0);
        check("rst_ram_in", ram_in, 0);
        check("rst_out_data", out_data, 16'hD000);
        #4 reset_n = 1'b1;
        preload = 1'b0;
        cycle();

        // Short burst; address 3 keeps its preload value.
        bd[0] = 16'hAAAA; bd[1] = 16'h5555; bd[2] = 16'h0001;
        do_burst(3, -1, 0, -1, -1);
        check("short_mem3", mem[3], 16'hD003);

        // Full 8-word burst.
        for (int i = 0; i < 8; i++) bd[i] = 16'h1111 * C_WIDTH'(i + 1);
        do_burst(8, -1, 0, -1, -1);

        // Backpressure on the second drain word.
        bd[0] = 16'h0102; bd[1] = 16'h0304; bd[2] = 16'h0506; bd[3] = 16'h0708;
        do_burst(4, 1, 3, -1, -1);

        // Abort after 4 fill handshakes of an 8-word request.
        start  = 1'b1;
        len_m1 = 3'd7;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hA000 + C_WIDTH'(i);
            cycle();
        end
        in_data = 16'hBEEF;
        abort   = 1'b1;
        @(negedge clock);
        check("abort_load", ram_load, 0);
        check("abort_ready", in_ready, 0);
        cycle();
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("abort_busy", busy, 0);
        check("abort_mem4", mem[4], 16'h5555);
        check("abort_mem3", mem[3], 16'hA003);
        cycle();
        bd[0] = 16'h0F0F;
        do_burst(1, -1, 0, -1, -1);

        // Start asserted with len_m1=0 during FILL is ignored.
        bd[0] = 16'h1234; bd[1] = 16'h2345; bd[2] = 16'h3456; bd[3] = 16'h4567;
        do_burst(4, -1, 0, 1, -1);

        // Asynchronous reset during the third drain word.
        bd[0] = 16'h0011; bd[1] = 16'h0022; bd[2] = 16'h0033; bd[3] = 16'h0044;
        do_burst(4, -1, 0, -1, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_rst_busy", busy, 0);
            check("post_rst_valid", out_valid, 0);
            cycle();
        end
        bd[0] = 16'h7777; bd[1] = 16'h8888;
        do_burst(2, -1, 0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
